// File: rtl/dsp48e2.sv
// rtl/dsp48e2.sv - reduced DSP48E2 slice: SIMD 48-bit add/sub with W/X/Y/Z muxes
// No multiplier; lanes of 48, 24 or 12 bits with the carry chain cut at lane edges.
module dsp48e2 #(
    parameter string       USE_SIMD = "ONE48",
    parameter int          AREG     = 0,
    parameter int          BREG     = 0,
    parameter int          CREG     = 0,
    parameter int          PREG     = 0,
    parameter logic [47:0] RND      = 48'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic [3:0]  alumode,
    input  logic [8:0]  opmode,
    input  logic        carryin,
    input  logic [29:0] a,
    input  logic [17:0] b,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    output logic [47:0] p,
    output logic [3:0]  carryout
);
    localparam int NL = (USE_SIMD == "FOUR12") ? 4 : (USE_SIMD == "TWO24") ? 2 : 1;
    localparam int LW = 48 / NL;

    logic [29:0] a_op;
    logic [17:0] b_op;
    logic [47:0] c_op, p_fb, ab_op;
    logic [47:0] w_op, x_op, y_op, z_op, p_d;
    logic [NL-1:0] lane_co;
    logic [3:0] co_d;

    if (USE_SIMD != "ONE48" && USE_SIMD != "TWO24" && USE_SIMD != "FOUR12") begin : g_bad_simd
        $fatal(1, "dsp48e2: illegal USE_SIMD value");
    end

    if (AREG == 1) begin : g_areg
        logic [29:0] a_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)   a_q <= '0;
            else if (ce) a_q <= a;
        end
        assign a_op = a_q;
    end else begin : g_abyp
        assign a_op = a;
    end

    if (BREG == 1) begin : g_breg
        logic [17:0] b_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)   b_q <= '0;
            else if (ce) b_q <= b;
        end
        assign b_op = b_q;
    end else begin : g_bbyp
        assign b_op = b;
    end

    if (CREG == 1) begin : g_creg
        logic [47:0] c_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)   c_q <= '0;
            else if (ce) c_q <= c;
        end
        assign c_op = c_q;
    end else begin : g_cbyp
        assign c_op = c;
    end

    assign ab_op = {a_op, b_op};

    always_comb begin
        x_op = '0;
        y_op = '0;
        z_op = '0;
        w_op = '0;
        case (opmode[1:0])
            2'b10:   x_op = p_fb;
            2'b11:   x_op = ab_op;
            default: x_op = '0;
        endcase
        case (opmode[3:2])
            2'b10:   y_op = '1;
            2'b11:   y_op = c_op;
            default: y_op = '0;
        endcase
        case (opmode[6:4])
            3'b001:  z_op = pcin;
            3'b010:  z_op = p_fb;
            3'b011:  z_op = c_op;
            3'b101:  z_op = $signed(pcin) >>> 17;
            3'b110:  z_op = $signed(p_fb) >>> 17;
            default: z_op = '0;
        endcase
        case (opmode[8:7])
            2'b01:   w_op = p_fb;
            2'b10:   w_op = RND;
            2'b11:   w_op = c_op;
            default: w_op = '0;
        endcase
    end

    // Each lane works two bits wider so bit LW is its carry/borrow out.
    for (genvar k = 0; k < NL; k++) begin : g_lane
        localparam logic [LW+1:0] ONE = 1;
        logic [LW+1:0] w_l, x_l, y_l, z_l, cin_l, t_l, s_l, r_l;
        always_comb begin
            w_l   = {2'b00, w_op[k*LW +: LW]};
            x_l   = {2'b00, x_op[k*LW +: LW]};
            y_l   = {2'b00, y_op[k*LW +: LW]};
            z_l   = {2'b00, z_op[k*LW +: LW]};
            cin_l = {{(LW+1){1'b0}}, (k == 0) ? carryin : 1'b0};
            t_l   = w_l + x_l + y_l + cin_l;
            s_l   = t_l + z_l;
            case (alumode)
                4'b0011: r_l = z_l - t_l;
                4'b0001: r_l = t_l - z_l - ONE;
                4'b0010: r_l = {s_l[LW+1:LW], ~s_l[LW-1:0]};
                default: r_l = s_l;
            endcase
        end
        assign p_d[k*LW +: LW] = r_l[LW-1:0];
        assign lane_co[k]      = r_l[LW];
    end

    // Lane carries land on the top carryout bit of the 12-bit groups they span.
    always_comb begin
        co_d = '0;
        for (int k = 0; k < NL; k++) begin
            co_d[(k + 1) * (4 / NL) - 1] = lane_co[k];
        end
    end

    if (PREG == 1) begin : g_preg
        logic [47:0] p_q;
        logic [3:0]  co_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                p_q  <= '0;
                co_q <= '0;
            end else if (ce) begin
                p_q  <= p_d;
                co_q <= co_d;
            end
        end
        assign p        = p_q;
        assign carryout = co_q;
        assign p_fb     = p_q;
    end else begin : g_pbyp
        assign p        = p_d;
        assign carryout = co_d;
        assign p_fb     = '0;
    end
endmodule

// File: tb/tb_dsp48e2.sv
// tb/tb_dsp48e2.sv - directed scoreboard bench for dsp48e2 across SIMD/register configurations
module tb_dsp48e2;
    logic        clock = 1'b0;
    logic        reset, ce, carryin;
    logic [3:0]  alumode;
    logic [8:0]  opmode;
    logic [47:0] ab, c, pcin;
    logic [47:0] p0, p1, p2, p3;
    logic [3:0]  co0, co1, co2, co3;

    typedef struct {
        string       tag;
        logic [47:0] exp;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dsp48e2 #(.USE_SIMD("FOUR12")) u0 (
        .clock(clock), .reset(reset), .ce(ce), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(ab[47:18]), .b(ab[17:0]), .c(c), .pcin(pcin),
        .p(p0), .carryout(co0));

    dsp48e2 #(.RND(48'h800)) u1 (
        .clock(clock), .reset(reset), .ce(ce), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(ab[47:18]), .b(ab[17:0]), .c(c), .pcin(pcin),
        .p(p1), .carryout(co1));

    dsp48e2 #(.PREG(1)) u2 (
        .clock(clock), .reset(reset), .ce(ce), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(ab[47:18]), .b(ab[17:0]), .c(c), .pcin(pcin),
        .p(p2), .carryout(co2));

    dsp48e2 #(.USE_SIMD("TWO24"), .AREG(1), .BREG(1), .CREG(1), .PREG(1)) u3 (
        .clock(clock), .reset(reset), .ce(ce), .alumode(alumode), .opmode(opmode),
        .carryin(carryin), .a(ab[47:18]), .b(ab[17:0]), .c(c), .pcin(pcin),
        .p(p3), .carryout(co3));

    task automatic sb_push(input string tag, input logic [47:0] e);
        exp_t ent;
        ent.tag = tag;
        ent.exp = e;
        sb.push_back(ent);
    endtask

    task automatic sb_check(input logic [47:0] obs);
        exp_t ent;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected entry", obs);
        end else begin
            ent = sb.pop_front();
            assert (obs === ent.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", ent.tag, obs, ent.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; carryin = 1'b0; alumode = 4'b0000;
        opmode = 9'b0; ab = '0; c = '0; pcin = '0;
        #12;
        sb_push("reset_p", 48'h0);        sb_check(p2);
        sb_push("reset_co", 48'h0);       sb_check({44'h0, co2});
        reset = 1'b0;

        opmode = 9'b000110011; ab = 48'h000FFF8000FF; c = 48'h000001800001;
        sb_push("four12_p", 48'h000000000100);
        sb_push("four12_co", 48'h6);
        #1; sb_check(p0); sb_check({44'h0, co0});

        ab = 48'h000000FFFFFF; c = 48'h1; carryin = 1'b1;
        sb_push("one48_p", 48'h000001000001);
        sb_push("one48_co", 48'h0);
        #1; sb_check(p1); sb_check({44'h0, co1});
        carryin = 1'b0;

        opmode = 9'b100000000;
        sb_push("rnd_w", 48'h800);
        #1; sb_check(p1);

        opmode = 9'b000001110; ab = '0; c = 48'h7;
        sb_push("xp_preg0", 48'h7);
        #1; sb_check(p1);

        opmode = 9'b000110011; ab = 48'd10; c = 48'd3; alumode = 4'b0001;
        sb_push("alu_0001", 48'd6);
        #1; sb_check(p1);

        ab = '0; c = '0; alumode = 4'b0010;
        sb_push("alu_not", 48'hFFFFFFFFFFFF);
        #1; sb_check(p1);
        alumode = 4'b0000;

        opmode = 9'b000100011; ab = 48'd5; ce = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sb_push($sformatf("accum_%0d", i), 48'(5 * i));
            tick();
            sb_check(p2);
        end
        ce = 1'b0;
        sb_push("ce_hold", 48'd20);
        tick(); tick();
        sb_check(p2);

        #2 reset = 1'b1;
        sb_push("async_reset", 48'h0);
        #1; sb_check(p2);
        ce = 1'b1;
        sb_push("reset_wins", 48'h0);
        tick();
        sb_check(p2);
        ce = 1'b0;
        reset = 1'b0;

        alumode = 4'b0011; opmode = 9'b000110000;
        c = 48'h000010000003; ab = '0; ce = 1'b1;
        sb_push("sub_lat1", 48'h0);
        tick(); sb_check(p3);
        sb_push("sub_c_only", 48'h000010000003);
        tick(); sb_check(p3);
        opmode = 9'b000110011; ab = 48'h000001000005;
        sb_push("sub_ab_lat", 48'h000010000003);
        tick(); sb_check(p3);
        sb_push("sub_ab", 48'h00000FFFFFFE);
        tick(); sb_check(p3);

        alumode = 4'b0000; ce = 1'b0;
        reset = 1'b1; #2; reset = 1'b0;
        opmode = 9'b000000011; ab = 48'h800000000000; ce = 1'b1;
        sb_push("load_p", 48'h800000000000);
        tick(); sb_check(p2);
        opmode = 9'b001100000;
        sb_push("p_shift17", 48'hFFFFC0000000);
        tick(); sb_check(p2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
